// File: rtl/calibration_pattern_tx.sv
// Streams one frame of calibration colours: each LED shows the selected bit of its own index.
// Optional feature: define CALIB_TX_INVERT_EN to add invert_in, which swaps COLOR_0/COLOR_1 per frame.
module calibration_pattern_tx #(
    parameter int          NUM_LEDS          = 50,
    parameter int          LED_ADDRESS_WIDTH = 10,
    parameter logic [23:0] COLOR_0           = 24'h00_00_FF,
    parameter logic [23:0] COLOR_1           = 24'hFF_00_00,
    parameter logic [23:0] COLOR_OFF         = 24'h00_00_00,
    parameter int          LATCH_CYCLES      = 20000,
    localparam int         BIT_W             = $clog2(LED_ADDRESS_WIDTH) + 1,
    localparam int         CNT_W             = $clog2(LATCH_CYCLES + 1)
) (
    input  logic                         clk_pixel,
    input  logic                         rst_n,
    input  logic                         start_in,
    input  logic [BIT_W-1:0]             bit_index_in,
`ifdef CALIB_TX_INVERT_EN
    input  logic                         invert_in,
`endif
    output logic [23:0]                  color_out,
    output logic                         color_valid_out,
    input  logic                         color_ready_in,
    output logic                         last_out,
    output logic [LED_ADDRESS_WIDTH-1:0] led_index_out,
    output logic                         busy_out,
    output logic                         done_out,
    output logic [1:0]                   state_out
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] STREAM = 2'd1;
    localparam logic [1:0] LATCH  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]                   state;
    logic [LED_ADDRESS_WIDTH-1:0] led_index;
    logic [BIT_W-1:0]             bit_sel;
    logic                         invert_q;
    logic                         invert_sample;
    logic [CNT_W-1:0]             latch_cnt;
    logic                         start_q;
    logic                         start_seen_low;
    logic                         start_edge;
    logic                         is_last;
    logic                         xfer;
    logic                         led_bit;

`ifdef CALIB_TX_INVERT_EN
    assign invert_sample = invert_in;
`else
    assign invert_sample = 1'b0;
`endif

    // A level already high when reset releases must fall before it can count as an edge.
    assign start_edge = start_in && !start_q && start_seen_low;
    assign is_last    = (led_index == LED_ADDRESS_WIDTH'(NUM_LEDS - 1));
    // Stream handshake: a beat moves on a rising clk_pixel edge where color_valid_out and
    // color_ready_in are both 1; while valid waits on ready, colour/index/last hold still.
    assign xfer       = (state == STREAM) && color_ready_in;
    assign led_bit    = |(led_index & (LED_ADDRESS_WIDTH'(1) << bit_sel));

    always_ff @(posedge clk_pixel) begin
        if (!rst_n) begin
            state          <= IDLE;
            led_index      <= '0;
            bit_sel        <= '0;
            invert_q       <= 1'b0;
            latch_cnt      <= '0;
            start_q        <= 1'b0;
            start_seen_low <= 1'b0;
        end else begin
            start_q <= start_in;
            if (!start_in) start_seen_low <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_edge) begin
                        bit_sel   <= bit_index_in;
                        invert_q  <= invert_sample;
                        led_index <= '0;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (xfer) begin
                        if (is_last) begin
                            latch_cnt <= '0;
                            state     <= LATCH;
                        end else begin
                            led_index <= led_index + LED_ADDRESS_WIDTH'(1);
                        end
                    end
                end
                LATCH: begin
                    if (latch_cnt == CNT_W'(LATCH_CYCLES - 1)) state <= DONE;
                    else latch_cnt <= latch_cnt + CNT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        color_out = '0;
        if (state == STREAM) begin
            if (bit_sel >= BIT_W'(LED_ADDRESS_WIDTH)) color_out = COLOR_OFF;
            else if (led_bit ^ invert_q)              color_out = COLOR_1;
            else                                      color_out = COLOR_0;
        end
    end

    assign color_valid_out = (state == STREAM);
    assign last_out        = (state == STREAM) && is_last;
    assign led_index_out   = led_index;
    assign busy_out        = (state != IDLE);
    assign done_out        = (state == DONE);
    assign state_out       = state;

endmodule

// File: tb/tb_calibration_pattern_tx.sv
// Directed bench for calibration_pattern_tx: frame content, stalls, out-of-range bit,
// start filtering, reset abort and (with CALIB_TX_INVERT_EN) colour inversion.
module tb_calibration_pattern_tx;

    localparam int          NUM   = 50;
    localparam int          LATCH = 8;
    localparam logic [23:0] C0    = 24'h00_00_FF;
    localparam logic [23:0] C1    = 24'hFF_00_00;
    localparam logic [23:0] COFF  = 24'h00_00_00;
    localparam logic [1:0]  S_IDLE = 2'd0, S_STREAM = 2'd1, S_LATCH = 2'd2, S_DONE = 2'd3;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic        start_in;
    logic [4:0]  bit_index_in;
    logic        invert;
    logic [23:0] color_out;
    logic        color_valid_out;
    logic        color_ready_in;
    logic        last_out;
    logic [9:0]  led_index_out;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  state_out;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          done_count = 0;
    logic [23:0] got_color [0:NUM-1];

    calibration_pattern_tx #(
        .NUM_LEDS(NUM), .LED_ADDRESS_WIDTH(10), .COLOR_0(C0), .COLOR_1(C1),
        .COLOR_OFF(COFF), .LATCH_CYCLES(LATCH)
    ) dut (
        .clk_pixel(clk_pixel),
        .rst_n(rst_n),
        .start_in(start_in),
        .bit_index_in(bit_index_in),
`ifdef CALIB_TX_INVERT_EN
        .invert_in(invert),
`endif
        .color_out(color_out),
        .color_valid_out(color_valid_out),
        .color_ready_in(color_ready_in),
        .last_out(last_out),
        .led_index_out(led_index_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .state_out(state_out)
    );

    always #5 clk_pixel = ~clk_pixel;

    always @(posedge clk_pixel) if (done_out === 1'b1) done_count <= done_count + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] exp_color(input int idx, input int b, input logic inv);
        logic bitv;
        if (b >= 10) return COFF;
        bitv = (((idx >> b) & 1) != 0);
        return (bitv ^ inv) ? C1 : C0;
    endfunction

    // Called at a negedge with start_in low. poke makes a second start edge mid-frame and
    // then holds start_in high through DONE; abort_at >= 0 pulls reset while that beat is offered.
    task automatic run_frame(input int b, input logic inv, input bit stall, input bit poke,
                             input int abort_at);
        int          exp_idx, xfers, lasts, guard, wait_n, d0;
        logic [23:0] held_c;
        logic [9:0]  held_i;
        logic        held_l;
        bit          was_stall, aborted;
        d0 = done_count;
        bit_index_in = b[4:0];
        invert = inv;
        start_in = 1'b1;
        @(negedge clk_pixel);
        check("first_valid", color_valid_out, 1'b1);
        check("first_state", state_out, S_STREAM);
        check("first_busy", busy_out, 1'b1);
        if (!poke) start_in = 1'b0;
        exp_idx = 0; xfers = 0; lasts = 0; guard = 0; was_stall = 0; aborted = 0;
        while (xfers < NUM && guard < 400) begin
            guard++;
            if (was_stall) begin
                check("stall_color", color_out, held_c);
                check("stall_index", led_index_out, held_i);
                check("stall_last", last_out, held_l);
            end
            check("valid", color_valid_out, 1'b1);
            check("index", led_index_out, exp_idx[9:0]);
            check("color", color_out, exp_color(exp_idx, b, inv));
            check("last", last_out, exp_idx == NUM - 1);
            got_color[exp_idx] = color_out;
            if (poke && exp_idx == 5) start_in = 1'b0;
            if (poke && exp_idx == 8) start_in = 1'b1;
            color_ready_in = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (abort_at == xfers && color_ready_in) rst_n = 1'b0;
            if (color_ready_in && last_out) lasts++;
            held_c = color_out; held_i = led_index_out; held_l = last_out;
            was_stall = !color_ready_in;
            @(negedge clk_pixel);
            if (!rst_n) begin
                aborted = 1;
                break;
            end
            if (color_ready_in) begin
                xfers++;
                exp_idx++;
            end
        end
        if (aborted) begin
            check("abort_valid", color_valid_out, 1'b0);
            check("abort_busy", busy_out, 1'b0);
            check("abort_index", led_index_out, 10'd0);
            check("abort_state", state_out, S_IDLE);
            check("abort_done", done_out, 1'b0);
            rst_n = 1'b1;
            color_ready_in = 1'b0;
            @(negedge clk_pixel);
            return;
        end
        check("transfers", xfers, NUM);
        check("last_count", lasts, 1);
        color_ready_in = 1'($urandom_range(0, 1));
        check("latch_valid", color_valid_out, 1'b0);
        check("latch_state", state_out, S_LATCH);
        check("latch_busy", busy_out, 1'b1);
        wait_n = 0;
        while (done_out !== 1'b1 && wait_n < 100) begin
            @(negedge clk_pixel);
            wait_n++;
        end
        // done appears in the (LATCH+1)th cycle after the final transfer cycle
        check("done_latency", wait_n, LATCH);
        check("done_state", state_out, S_DONE);
        @(negedge clk_pixel);
        check("done_pulse_end", done_out, 1'b0);
        check("idle_busy", busy_out, 1'b0);
        check("done_count", done_count - d0, 1);
        color_ready_in = 1'b0;
        if (poke) begin
            repeat (4) begin
                @(negedge clk_pixel);
                check("no_retrigger", busy_out, 1'b0);
            end
            start_in = 1'b0;
        end
        @(negedge clk_pixel);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start_in = 1'b0; bit_index_in = '0; invert = 1'b0; color_ready_in = 1'b0;
        repeat (3) @(negedge clk_pixel);
        check("rst_valid", color_valid_out, 1'b0);
        check("rst_busy", busy_out, 1'b0);
        check("rst_done", done_out, 1'b0);
        check("rst_last", last_out, 1'b0);
        check("rst_index", led_index_out, 10'd0);
        check("rst_color", color_out, 24'd0);
        check("rst_state", state_out, S_IDLE);
        rst_n = 1'b1;
        @(negedge clk_pixel);

        // bit 0, ready always high
        run_frame(0, 1'b0, 1'b0, 1'b0, -1);
        check("b0_led0", got_color[0], C0);
        check("b0_led1", got_color[1], C1);
        check("b0_led49", got_color[49], C1);

        // bit 5 with random stalls
        run_frame(5, 1'b0, 1'b1, 1'b0, -1);
        check("b5_led31", got_color[31], C0);
        check("b5_led32", got_color[32], C1);
        check("b5_led49", got_color[49], C1);

        // out-of-range bit index
        run_frame(12, 1'b0, 1'b0, 1'b0, -1);
        check("b12_led0", got_color[0], COFF);
        check("b12_led49", got_color[49], COFF);

        // extra start edge mid-frame, start held through DONE
        run_frame(1, 1'b0, 1'b0, 1'b1, -1);

        // reset at transfer 20, then a clean frame from index 0
        run_frame(3, 1'b0, 1'b0, 1'b0, 20);
        d0 = done_count;
        repeat (30) @(negedge clk_pixel);
        check("abort_no_done", done_count - d0, 0);
        check("abort_idle", busy_out, 1'b0);
        run_frame(2, 1'b0, 1'b0, 1'b0, -1);

        // start already high when reset releases
        start_in = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk_pixel);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk_pixel);
            check("held_start_idle", busy_out, 1'b0);
        end
        start_in = 1'b0;
        @(negedge clk_pixel);
        run_frame(4, 1'b0, 1'b0, 1'b0, -1);
        check("b4_led16", got_color[16], C1);
        check("b4_led15", got_color[15], C0);

`ifdef CALIB_TX_INVERT_EN
        run_frame(0, 1'b1, 1'b0, 1'b0, -1);
        check("inv_led0", got_color[0], C1);
        check("inv_led1", got_color[1], C0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
